// File: rtl/scenario_loader_pkg.sv
// Shared constants and types for the scenario loader and its neighbours.
package scenario_loader_pkg;

    localparam int unsigned DEF_SPRITES    = 4;
    localparam int unsigned DEF_DIMENSIONS = 2;
    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned SEL_W          = 16;

    typedef logic [DEF_DIMENSIONS-1:0][DEF_WIDTH-1:0] body_vec_t;
    typedef body_vec_t [DEF_SPRITES-1:0]               all_bodies_t;

    typedef logic [1:0] loader_state_t;
    localparam loader_state_t LATCH = 2'd0;
    localparam loader_state_t HOLD  = 2'd1;
    localparam loader_state_t RUN   = 2'd2;

endpackage

// File: rtl/scenario_loader_if.sv
// Bundle between the loader, the scenario table and the physics engine.
interface scenario_loader_if import scenario_loader_pkg::*; #(
    parameter int unsigned SPRITES    = DEF_SPRITES,
    parameter int unsigned DIMENSIONS = DEF_DIMENSIONS,
    parameter int unsigned WIDTH      = DEF_WIDTH
) ();
    localparam int unsigned VEC_W = SPRITES * DIMENSIONS * WIDTH;

    logic [SEL_W-1:0] sel_stable;
    logic [VEC_W-1:0] tbl_loc;
    logic [VEC_W-1:0] tbl_vel;
    logic [VEC_W-1:0] init_loc;
    logic [VEC_W-1:0] init_vel;
    logic             engine_rst_n;
    logic             loaded;
    logic             busy;

    modport master (
        output sel_stable, init_loc, init_vel, engine_rst_n, loaded, busy,
        input  tbl_loc, tbl_vel
    );

    modport slave (
        input  sel_stable, init_loc, init_vel, engine_rst_n, loaded, busy,
        output tbl_loc, tbl_vel
    );

endinterface

// File: rtl/scenario_loader_switch_debouncer.sv
// Synchronises the select switches and restart button and tracks how long a
// new select value has been steady.
module scenario_loader_switch_debouncer import scenario_loader_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = 1620000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_raw,
    input  logic             restart,
    input  logic [SEL_W-1:0] sel_stable,
    input  logic             clear,
    output logic [SEL_W-1:0] candidate,
    output logic             restart_s,
    output logic             mature
);
    localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SEL_W-1:0] sel_meta_q, sel_s_q, cand_q, cand_d;
    logic             restart_meta_q, restart_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sel_s_q != cand_q) begin
            cand_d = sel_s_q;
            cnt_d  = '0;
        end else if (clear) begin
            cnt_d = '0;
        end else if (cand_q != sel_stable && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_meta_q     <= '0;
            sel_s_q        <= '0;
            restart_meta_q <= 1'b0;
            restart_s_q    <= 1'b0;
            cand_q         <= '0;
            cnt_q          <= '0;
        end else begin
            sel_meta_q     <= sel_raw;
            sel_s_q        <= sel_meta_q;
            restart_meta_q <= restart;
            restart_s_q    <= restart_meta_q;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
        end
    end

    // Maturity ignores loader state; the caller gates the actual commit.
    assign mature    = (sel_s_q == cand_q) && (cand_q != sel_stable) && (cnt_q == CNT_MAX);
    assign candidate = cand_q;
    assign restart_s = restart_s_q;

endmodule

// File: rtl/scenario_loader.sv
// Commits debounced scenario selects, latches the table vectors and holds the
// physics engine in reset for a fixed window after every load.
module scenario_loader import scenario_loader_pkg::*; #(
    parameter int unsigned SPRITES         = DEF_SPRITES,
    parameter int unsigned DIMENSIONS      = DEF_DIMENSIONS,
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 1620000,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_raw,
    input  logic             restart,
    scenario_loader_if.master bus
);
    localparam int unsigned      VEC_W    = SPRITES * DIMENSIONS * WIDTH;
    localparam int unsigned      HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    loader_state_t     state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [VEC_W-1:0]  loc_q, loc_d, vel_q, vel_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              eng_q, eng_d, loaded_q, loaded_d, restart_q;
    logic [SEL_W-1:0]  candidate;
    logic              restart_s, mature, commit, restart_rise;

    assign commit       = mature && (state_q == RUN);
    assign restart_rise = restart_s && !restart_q;

    scenario_loader_switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_raw   (sel_raw),
        .restart   (restart),
        .sel_stable(sel_q),
        .clear     (commit),
        .candidate (candidate),
        .restart_s (restart_s),
        .mature    (mature)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        loc_d    = loc_q;
        vel_d    = vel_q;
        sel_d    = sel_q;
        loaded_d = 1'b0;
        case (state_q)
            LATCH: begin
                loc_d   = bus.tbl_loc;
                vel_d   = bus.tbl_vel;
                hold_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_MAX) begin
                    state_d  = RUN;
                    loaded_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                // A commit wins over a simultaneous restart: one reload, new select.
                if (commit) begin
                    sel_d   = candidate;
                    state_d = LATCH;
                end else if (restart_rise) begin
                    state_d = LATCH;
                end
            end
            default: state_d = LATCH;
        endcase
        eng_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LATCH;
            hold_q    <= '0;
            loc_q     <= '0;
            vel_q     <= '0;
            sel_q     <= '0;
            eng_q     <= 1'b0;
            loaded_q  <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            loc_q     <= loc_d;
            vel_q     <= vel_d;
            sel_q     <= sel_d;
            eng_q     <= eng_d;
            loaded_q  <= loaded_d;
            restart_q <= restart_s;
        end
    end

    assign bus.sel_stable   = sel_q;
    assign bus.init_loc     = loc_q;
    assign bus.init_vel     = vel_q;
    assign bus.engine_rst_n = eng_q;
    assign bus.loaded       = loaded_q;
    assign bus.busy         = (state_q != RUN);

endmodule

// File: tb/tb_scenario_loader.sv
// Self-checking bench for scenario_loader with a behavioural scenario table
// and a scoreboard of expected loads.
module tb_scenario_loader;
    import scenario_loader_pkg::*;

    localparam int unsigned DEB_CYCLES = 8;
    localparam int unsigned HOLD_CYC   = 4;
    localparam int unsigned BUSY_LEN   = HOLD_CYC + 1;

    typedef struct packed {
        logic [15:0] sel;
        all_bodies_t loc;
        all_bodies_t vel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sel_raw = '0;
    logic        restart = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    int           busy_cnt = 0;
    logic         prev_eng = 1'b0;
    logic [511:0] snap;
    exp_t         mon_exp;
    all_bodies_t  vec_tmp;
    int           low_cnt;

    scenario_loader_if bus ();

    scenario_loader #(
        .SPRITES        (4),
        .DIMENSIONS     (2),
        .WIDTH          (32),
        .DEBOUNCE_CYCLES(DEB_CYCLES),
        .HOLD_CYCLES    (HOLD_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel_raw(sel_raw),
        .restart(restart),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    function automatic all_bodies_t tbl_loc_f(input logic [15:0] s);
        all_bodies_t r;
        for (int b = 0; b < 4; b++)
            for (int d = 0; d < 2; d++)
                r[b][d] = 32'h0100_0000 + (32'(s) << 16) + (32'(b) << 8);
        return r;
    endfunction

    function automatic all_bodies_t tbl_vel_f(input logic [15:0] s);
        all_bodies_t r;
        for (int b = 0; b < 4; b++) begin
            r[b][1] = (32'(s) << 20) + 32'(b);
            r[b][0] = 32'(b);
        end
        return r;
    endfunction

    assign bus.tbl_loc = tbl_loc_f(bus.sel_stable);
    assign bus.tbl_vel = tbl_vel_f(bus.sel_stable);

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] s);
        exp_t e;
        e.sel = s;
        e.loc = tbl_loc_f(s);
        e.vel = tbl_vel_f(s);
        sb_q.push_back(e);
    endtask

    task automatic wait_busy(input int max, input string tag);
        int n = 0;
        while (bus.busy !== 1'b1 && n < max) begin
            cyc();
            n++;
        end
        check_eq(tag, bus.busy, 1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (!(bus.busy === 1'b0 && bus.engine_rst_n === 1'b1) && n < max) begin
            cyc();
            n++;
        end
        check_eq(tag, {bus.busy, bus.engine_rst_n}, 2'b01);
    endtask

    // Monitor: reload window length, vector stability in HOLD, scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            prev_eng = 1'b0;
        end else begin
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (busy_cnt == 2)
                    snap = {bus.init_loc, bus.init_vel};
                else if (busy_cnt > 2)
                    check_eq("hold_vec_stable", {bus.init_loc, bus.init_vel}, snap);
            end
            if (bus.engine_rst_n === 1'b1 && prev_eng === 1'b0) begin
                check_eq("busy_len", busy_cnt, BUSY_LEN);
                check_eq("loaded_at_rise", bus.loaded, 1);
                busy_cnt = 0;
            end
            if (bus.loaded === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_load", 1, 0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_eq("load_sel", bus.sel_stable, mon_exp.sel);
                    check_eq("load_loc", bus.init_loc, mon_exp.loc);
                    check_eq("load_vel", bus.init_vel, mon_exp.vel);
                end
            end
            prev_eng = bus.engine_rst_n;
        end
    end

    initial begin
        repeat (3) cyc();
        check_eq("rst_sel", bus.sel_stable, 0);
        check_eq("rst_loc", bus.init_loc, 0);
        check_eq("rst_vel", bus.init_vel, 0);
        check_eq("rst_eng", bus.engine_rst_n, 0);
        check_eq("rst_loaded", bus.loaded, 0);
        check_eq("rst_busy", bus.busy, 1);

        // Scenario 0 loads after reset release.
        push_exp(16'd0);
        rst_n = 1'b1;
        wait_idle(40, "first_load_done");
        vec_tmp = bus.init_loc;
        check_eq("init_loc0", vec_tmp[0], {32'h0100_0000, 32'h0100_0000});
        repeat (5) cyc();

        // Held change 0 -> 1: commit exactly DEB_CYCLES edges after sampling.
        sel_raw = 16'd1;
        push_exp(16'd1);
        repeat (10) cyc();
        check_eq("commit_not_early", bus.sel_stable, 0);
        cyc();
        check_eq("commit_edge", bus.sel_stable, 1);
        check_eq("commit_busy", bus.busy, 1);
        wait_idle(40, "sel1_load_done");
        vec_tmp = bus.init_vel;
        check_eq("init_vel0", vec_tmp[0], {32'h0010_0000, 32'h0});
        repeat (5) cyc();

        // Short glitch never commits.
        sel_raw = 16'd2;
        repeat (5) cyc();
        sel_raw = 16'd1;
        low_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (bus.engine_rst_n !== 1'b1 || bus.busy !== 1'b0) low_cnt++;
        end
        check_eq("glitch_no_reload", low_cnt, 0);
        check_eq("glitch_sel", bus.sel_stable, 1);

        // Restart reloads the same scenario; a second edge in HOLD is ignored.
        push_exp(16'd1);
        restart = 1'b1;
        repeat (2) cyc();
        restart = 1'b0;
        wait_busy(10, "restart_busy");
        repeat (2) cyc();
        restart = 1'b1;
        repeat (6) cyc();
        restart = 1'b0;
        wait_idle(40, "restart_done");
        repeat (10) cyc();
        check_eq("restart_single", sb_q.size(), 0);
        check_eq("restart_sel", bus.sel_stable, 1);

        // Select matures during HOLD and commits on the first RUN cycle.
        sel_raw = 16'd2;
        push_exp(16'd1);
        push_exp(16'd2);
        repeat (5) cyc();
        restart = 1'b1;
        repeat (2) cyc();
        restart = 1'b0;
        repeat (6) cyc();
        check_eq("mature_run_gap", {bus.busy, bus.loaded, bus.sel_stable}, {2'b01, 16'd1});
        cyc();
        check_eq("mature_commit", {bus.busy, bus.sel_stable}, {1'b1, 16'd2});
        wait_idle(40, "mature_done");
        repeat (5) cyc();
        check_eq("mature_drained", sb_q.size(), 0);

        // Reset mid-HOLD after a commit to 1 aborts the load.
        sel_raw = 16'd1;
        wait_busy(30, "pre_reset_busy");
        repeat (2) cyc();
        rst_n = 1'b0;
        sel_raw = 16'd0;
        cyc();
        check_eq("mid_rst_sel", bus.sel_stable, 0);
        check_eq("mid_rst_vec", {bus.init_loc, bus.init_vel}, 0);
        check_eq("mid_rst_eng", {bus.engine_rst_n, bus.loaded, bus.busy}, 3'b001);
        push_exp(16'd0);
        cyc();
        rst_n = 1'b1;
        wait_idle(40, "post_rst_load");
        check_eq("post_rst_sel", bus.sel_stable, 0);
        repeat (5) cyc();
        check_eq("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
